// File: rtl/conv3x3_mac_accumulator.sv
// Sequential 3x3 convolution MAC: accumulates NUM_TAPS pixel*weight products plus a
// bias in Q4.12, then presents one saturated Q4.12 result on a valid/ready port.
module conv3x3_mac_accumulator #(
    parameter int NUM_TAPS  = 9,
    parameter int FRAC_BITS = 12,
    parameter int ACC_W     = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] pixel,
    input  logic signed [15:0] weight,
    input  logic signed [15:0] bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] acc_out,
    output logic               sat_flag,
    output logic               busy
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam int R_W   = ACC_W - FRAC_BITS;

    localparam logic signed [R_W-1:0] MAX_R = {{(R_W-16){1'b0}}, 16'h7FFF};
    localparam logic signed [R_W-1:0] MIN_R = {{(R_W-16){1'b1}}, 16'h8000};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CNT_W-1:0]        r_tapCnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      r_accOut;
    logic                    r_satFlag;

    logic                    w_accept;
    logic                    w_lastTap;
    logic                    w_handshake;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_prodExt;
    logic signed [ACC_W-1:0] w_biasExt;
    logic signed [ACC_W-1:0] w_accNext;
    logic signed [R_W-1:0]   w_r;
    logic signed [15:0]      w_sat;
    logic                    w_satFlag;

    // The first tap of a window seeds the sum with the bias aligned to the product's binary point.
    assign w_prod      = pixel * weight;
    assign w_prodExt   = {{(ACC_W-32){w_prod[31]}}, w_prod};
    assign w_biasExt   = {{(ACC_W-16-FRAC_BITS){bias[15]}}, bias, {FRAC_BITS{1'b0}}};
    assign w_accNext   = (r_state == IDLE) ? (w_biasExt + w_prodExt) : (r_acc + w_prodExt);
    assign w_r         = w_accNext[ACC_W-1:FRAC_BITS];
    assign w_accept    = in_valid & in_ready;
    assign w_handshake = out_valid & out_ready;

    always_comb begin
        w_sat     = w_r[15:0];
        w_satFlag = 1'b0;
        if (w_r > MAX_R) begin
            w_sat     = 16'sh7FFF;
            w_satFlag = 1'b1;
        end else if (w_r < MIN_R) begin
            w_sat     = 16'sh8000;
            w_satFlag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_lastTap   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready  = 1'b1;
                w_lastTap = (NUM_TAPS == 1);
                if (in_valid) begin
                    w_nextState = w_lastTap ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                w_lastTap = (r_tapCnt == CNT_W'(NUM_TAPS - 1));
                if (in_valid && w_lastTap) begin
                    w_nextState = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Result is captured together with the last tap so it is stable for the whole OUTPUT stay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tapCnt  <= '0;
            r_acc     <= '0;
            r_accOut  <= '0;
            r_satFlag <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= w_accNext;
            r_tapCnt <= (r_state == IDLE) ? CNT_W'(1) : (r_tapCnt + CNT_W'(1));
            if (w_lastTap) begin
                r_accOut  <= w_sat;
                r_satFlag <= w_satFlag;
            end
        end else if (w_handshake) begin
            r_acc    <= '0;
            r_tapCnt <= '0;
        end
    end

    assign acc_out  = r_accOut;
    assign sat_flag = r_satFlag;

endmodule
